// File: rtl/au_pkg.sv
// Shared definitions for the add/sub unit and the sequential multiplier built on it.
package au_pkg;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_INC = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b100;
    localparam logic [2:0] SEL_DEC = 3'b110;

    localparam int AU_WIDTH = 32;
    localparam int AU_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/au_mul_seq_if.sv
// Request/response handshake bundle between the decode stage and the sequential multiplier.
interface au_mul_seq_if #(
    parameter int WIDTH = 32
);

    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_prod
    );

endinterface

// File: rtl/au.sv
// Combinational 32-bit add/sub unit shared by the execute stage and the multiplier.
module au
    import au_pkg::*;
#(
    parameter int WIDTH = AU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    logic [WIDTH:0] sum;

    // Subtraction carry-out is the inverted borrow (a + ~b + 1).
    always_comb begin
        sum = '0;
        case (sel)
            SEL_ADD: sum = {1'b0, a} + {1'b0, b};
            SEL_INC: sum = {1'b0, a} + (WIDTH+1)'(1);
            SEL_SUB: sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            SEL_DEC: sum = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
            default: sum = {1'b0, a} + {1'b0, b};
        endcase
    end

    assign out  = sum[WIDTH-1:0];
    assign cout = sum[WIDTH];

endmodule

// File: rtl/au_mul_seq_ctrl.sv
// Multiplier sequencing FSM and iteration counter; emits load/step strobes to the datapath.
module au_mul_seq_ctrl
    import au_pkg::*;
#(
    parameter int WIDTH = AU_WIDTH,
    parameter int CNT_W = AU_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic rsp_ready,
    input  logic skip,
    output logic req_ready,
    output logic rsp_valid,
    output logic load,
    output logic step
);

    mul_state_t       state_q;
    mul_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last;

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load)
                cnt_q <= '0;
            else if (step)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // A zero-skip request bypasses RUN entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = skip ? DONE : RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                load      = req_valid;
            end
            RUN:     step      = 1'b1;
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/au_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the external au for each accumulate step.
// Optional: define AU_MUL_SEQ_ZERO_SKIP_EN to short-circuit zero operands straight to DONE.
module au_mul_seq
    import au_pkg::*;
#(
    parameter int WIDTH = AU_WIDTH,
    parameter int CNT_W = AU_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    au_mul_seq_if.slave      bus,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [2:0]       au_sel,
    input  logic [WIDTH-1:0] au_out,
    input  logic             au_cout
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             load;
    logic             step;
    logic             skip;

`ifdef AU_MUL_SEQ_ZERO_SKIP_EN
    assign skip = (bus.req_a == '0) || (bus.req_b == '0);
`else
    assign skip = 1'b0;
`endif

    au_mul_seq_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bus.req_valid),
        .rsp_ready (bus.rsp_ready),
        .skip      (skip),
        .req_ready (bus.req_ready),
        .rsp_valid (bus.rsp_valid),
        .load      (load),
        .step      (step)
    );

    // The au sum is W+1 bits {cout,out}; shifting it right by one folds its LSB into lo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            mcand <= bus.req_a;
            hi    <= '0;
            lo    <= skip ? '0 : bus.req_b;
        end else if (step) begin
            hi <= {au_cout, au_out[WIDTH-1:1]};
            lo <= {au_out[0], lo[WIDTH-1:1]};
        end
    end

    assign au_a   = step ? hi : '0;
    assign au_b   = (step && lo[0]) ? mcand : '0;
    assign au_sel = SEL_ADD;

    assign bus.rsp_prod = {hi, lo};

endmodule

// File: tb/tb_au_mul_seq.sv
// Scoreboard bench for au_mul_seq driving a real au instance; 64-bit multiply is the reference.
module tb_au_mul_seq;
    import au_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] au_a;
    logic [W-1:0] au_b;
    logic [W-1:0] au_out;
    logic [2:0]   au_sel;
    logic         au_cout;

    int checks   = 0;
    int failures = 0;
    logic [63:0] expq[$];

    au_mul_seq_if #(.WIDTH(W)) bus ();

    au_mul_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .au_a    (au_a),
        .au_b    (au_b),
        .au_sel  (au_sel),
        .au_out  (au_out),
        .au_cout (au_cout)
    );

    au #(.WIDTH(W)) u_au (
        .a    (au_a),
        .b    (au_b),
        .sel  (au_sel),
        .out  (au_out),
        .cout (au_cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef AU_MUL_SEQ_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 1;
`endif
        return W;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.req_ready !== 1'b1) check("req_ready_timeout", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        expq.push_back(model(a, b));
    endtask

    // Counts edges from the accepting edge until rsp_valid; optionally pulses a stray request mid-run.
    task automatic wait_rsp(input int lat, input bit stray);
        int n = 0;
        logic sel_bad = 1'b0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            if (au_sel !== SEL_ADD) sel_bad = 1'b1;
            if (stray && n == 5) begin
                bus.req_valid = 1'b1;
                bus.req_a     = 32'd7;
                bus.req_b     = 32'd7;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.req_valid = 1'b0;
        check("latency", 64'(n), 64'(lat));
        check("au_sel_run", 64'(sel_bad), 64'd0);
    endtask

    task automatic consume(input int hold, input logic [63:0] exp, input bit req_during_hold);
        if (req_during_hold) begin
            bus.req_valid = 1'b1;
            bus.req_a     = 32'd9;
            bus.req_b     = 32'd9;
        end
        for (int i = 0; i < hold; i++) begin
            check("prod_hold", bus.rsp_prod, exp);
            check("rsp_valid_hold", 64'(bus.rsp_valid), 64'd1);
            check("req_ready_done", 64'(bus.req_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("back_to_idle", 64'({bus.rsp_valid, bus.req_ready}), 64'b01);
        bus.req_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input int hold);
        issue(a, b);
        wait_rsp(exp_lat(a, b), 1'b0);
        consume(hold, model(a, b), 1'b0);
    endtask

    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (expq.size() == 0) begin
                    check("sb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("sb_prod", bus.rsp_prod, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [31:0] b;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_prod", bus.rsp_prod, 64'd0);
        check("rst_au_ab", {au_a, au_b}, 64'd0);
        check("rst_au_sel", 64'(au_sel), 64'(SEL_ADD));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run(32'd3, 32'd5, 1);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

        issue(32'h8000_0000, 32'd2);
        wait_rsp(W, 1'b0);
        consume(10, 64'h0000_0001_0000_0000, 1'b1);

        issue(32'h0001_2345, 32'd300);
        wait_rsp(W, 1'b1);
        consume(1, model(32'h0001_2345, 32'd300), 1'b0);
        run(32'd7, 32'd7, 1);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (15) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrun_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrun_req_ready", 64'(bus.req_ready), 64'd1);
        check("midrun_au_ab", {au_a, au_b}, 64'd0);
        void'(expq.pop_back());
        @(posedge clk); #1 reset = 1'b0;
        run(32'd10, 32'd10, 1);

        run(32'd0, 32'h1234, 1);
        run(32'd1, 32'hDEAD_BEEF, 0);

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = '0;
                1: b = 32'd1;
                default: ;
            endcase
            run(a, b, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
